fetch_hazard_ctrl: RTL
======================

Name: fetch_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage datapath (IF/ID/EX/MEM/WB); drives the program_counter enable and all inter-stage register write/flush controls.
- Detects load-use hazards (ID vs EX) and produces the one-cycle stall.
- Sequences the flush of wrong-path instructions when a branch resolves taken in MEM (pc_source=1).
- Arbitrates an external stall request (instruction-ROM loader / debug halt) against both.

Parameters:
- REG_ADDR_W, 5, register specifier width
- EXT_STALL_MAX, 15, max consecutive cycles ext_stall may be honoured before watchdog flag
- CNT_W, 16, width of performance counters (optional feature)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (asserted at 0); clears all state
- id_rs  in  REG_ADDR_W  source reg 1 of instruction in ID
- id_rt  in  REG_ADDR_W  source reg 2 of instruction in ID
- id_uses_rt  in  1  ID instruction actually reads rt
- ex_rt  in  REG_ADDR_W  destination of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- pc_source  in  1  branch taken, resolved in MEM this cycle
- ext_stall  in  1  external freeze request
- pc_write  out  1  enable for program_counter
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_flush  out  1  ID/EX clear to NOP (bubble)
- exmem_flush  out  1  EX/MEM clear to NOP
- state  out  2  current FSM state (debug)
- stall_wdog  out  1  sticky: ext_stall exceeded EXT_STALL_MAX

Behaviour:
- States: RUN=0, LOAD_STALL=1, FREEZE=2. Encoding is fixed.
- Reset (reset=0, async): state=RUN, freeze counter=0, stall_wdog=0. Combinational outputs then reflect RUN with no hazard: pc_write=1, ifid_write=1, all flushes=0.
- Hazard term: hz = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)). Register 0 never causes a hazard.
- Priority per cycle: pc_source > ext_stall > hz.
- Branch (pc_source=1, any state):
  - pc_write=1 and ifid_write=1 (PC loads pc_branch).
  - ifid_flush=1, idex_flush=1, exmem_flush=1; kills the 3 wrong-path instructions in the same cycle.
  - Next state=RUN; freeze counter cleared.
- ext_stall=1 without branch:
  - pc_write=0, ifid_write=0, no flushes.
  - Next state=FREEZE; counter increments, saturating at EXT_STALL_MAX.
  - stall_wdog sets when the counter equals EXT_STALL_MAX with ext_stall still 1; cleared only by reset.
- hz=1 in RUN without branch/ext_stall:
  - pc_write=0, ifid_write=0, idex_flush=1 (one bubble).
  - Next state=LOAD_STALL.
- LOAD_STALL:
  - Load has moved to MEM, so hz is normally 0. Outputs as RUN.
  - Next state=RUN.
  - If hz is re-asserted by a new load, it stalls again (back-to-back loads allowed, one bubble each).
- FREEZE with ext_stall=0: counter cleared; evaluate hz as in RUN; next state RUN or LOAD_STALL.
- Latency: controls are combinational from the current inputs and state; the state update takes effect on the next clock edge.
- Reset asserted mid-stall or mid-freeze: immediate return to RUN outputs; no pending bubble is retained.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined: adds outputs stall_cycles, flush_events, freeze_cycles (each CNT_W bits).
  - stall_cycles counts cycles with a hz stall.
  - flush_events counts cycles with pc_source=1.
  - freeze_cycles counts cycles with ext_stall honoured.
  - Counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - State encodings RUN/LOAD_STALL/FREEZE.
  - REG_ZERO constant.
  - Stage-index constants.
- One sub-module, hazard_detect: purely combinational hz term. Reused later by the forwarding unit.
- FSM, freeze counter and perf counters stay in the top module.

Test Plan:
- Reset low for 2 cycles with random inputs -> state=0, pc_write=1, ifid_write=1, all flushes=0, stall_wdog=0; hold through release.
- ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle -> pc_write=0, ifid_write=0, idex_flush=1; next cycle state=1 with ex_mem_read=0 -> RUN outputs; state=0 after.
- ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall. Also ex_rt=7, id_rt=7, id_uses_rt=0 -> no stall.
- pc_source=1 together with hz=1 and ext_stall=1 -> pc_write=1, ifid_flush=idex_flush=exmem_flush=1; next state=0.
- ext_stall=1 for 16 cycles with EXT_STALL_MAX=15 -> pc_write=0 throughout; stall_wdog rises at the cycle the counter hits 15 and stays 1 after ext_stall drops, until reset.
- With PIPE_PERF_CNT_EN: 3 hazard stalls, 2 branches, 4 freeze cycles -> stall_cycles=3, flush_events=2, freeze_cycles=4.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller:
// FSM state encodings, the hard-wired zero register and stage indices.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FREEZE     = 2'd2
    } state_e;

    localparam int REG_ZERO = 0;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard term: ID sources vs a load in EX.
// Ports: id_rs_i/id_rt_i/id_uses_rt_i, ex_rt_i/ex_mem_read_i in; hz_o out.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_i,
    input  logic                  ex_mem_read_i,
    output logic                  hz_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt_i == id_rs_i);
    assign rt_match = id_uses_rt_i & (ex_rt_i == id_rt_i);

    // Register zero is hard-wired, so a load into it never hazards.
    assign hz_o = ex_mem_read_i
                & (ex_rt_i != REG_ADDR_W'(REG_ZERO))
                & (rs_match | rt_match);

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Pipeline sequencing controller: PC/IF-ID enables and stage flushes
// for load-use stalls, taken branches (from MEM) and external freezes.
// Ports: clk, reset (async, active-low), hazard/branch/stall inputs;
// pc_write, ifid_write, *_flush, state, stall_wdog outputs.
// Optional PIPE_PERF_CNT_EN adds stall_cycles/flush_events/freeze_cycles.
module fetch_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W    = 5,
    parameter int EXT_STALL_MAX = 15,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_mem_read,
    input  logic                  pc_source,
    input  logic                  ext_stall,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic [1:0]            state,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events,
    output logic [CNT_W-1:0]      freeze_cycles,
`endif
    output logic                  stall_wdog
);

    localparam int FCW = $clog2(EXT_STALL_MAX + 1);
    localparam logic [FCW-1:0] FMAX = FCW'(EXT_STALL_MAX);

    state_e         state_q, state_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           wdog_q, wdog_d;
    logic           hz;
    logic           hz_stall;
    logic           freeze_hon;
    logic [2:0]     kill;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rt_i  (id_uses_rt),
        .ex_rt_i       (ex_rt),
        .ex_mem_read_i (ex_mem_read),
        .hz_o          (hz)
    );

    // Every state resolves the same priority; LOAD_STALL re-stalls on a
    // fresh load and FREEZE falls through to the hazard check on release.
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        wdog_d     = wdog_q;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        kill       = 3'b000;
        hz_stall   = 1'b0;
        freeze_hon = 1'b0;
        if (pc_source) begin
            kill    = 3'b111;
            state_d = RUN;
            fcnt_d  = '0;
        end else if (ext_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            freeze_hon = 1'b1;
            state_d    = FREEZE;
            if (fcnt_q == FMAX) begin
                wdog_d = 1'b1;
            end else begin
                fcnt_d = fcnt_q + FCW'(1);
            end
        end else begin
            fcnt_d = '0;
            if (hz) begin
                pc_write       = 1'b0;
                ifid_write     = 1'b0;
                kill[STG_ID]   = 1'b1;
                hz_stall       = 1'b1;
                state_d        = LOAD_STALL;
            end else begin
                state_d = RUN;
            end
        end
    end

    // kill[] names the stage whose instruction is squashed.
    assign ifid_flush  = kill[STG_IF];
    assign idex_flush  = kill[STG_ID];
    assign exmem_flush = kill[STG_EX];
    assign state       = state_q;
    assign stall_wdog  = wdog_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            wdog_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            wdog_q  <= wdog_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q, frz_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
            frz_q   <= '0;
        end else begin
            if (hz_stall && stall_q != '1) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (pc_source && flush_q != '1) begin
                flush_q <= flush_q + CNT_W'(1);
            end
            if (freeze_hon && frz_q != '1) begin
                frz_q <= frz_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles  = stall_q;
    assign flush_events  = flush_q;
    assign freeze_cycles = frz_q;
`else
    logic unused_ok;
    assign unused_ok = hz_stall | freeze_hon;
`endif

endmodule
